// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : 64-bit PC fetch stage feeding a one-entry valid/ready output
//            register, with redirect flush and misaligned-PC fault.
// Revision : 1.0
// ============================================================================
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        rom_ce_o,
    output logic [63:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_pc_o,
    output logic [31:0] out_inst_o,
    output logic        out_misalign_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [63:0] opc_q, opc_d;
    logic [31:0] inst_q, inst_d;
    logic        misalign_q, misalign_d;

    logic space;
    logic pc_aligned;

    assign space      = !valid_q || out_ready_i;
    assign pc_aligned = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            opc_q      <= 64'd0;
            inst_q     <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            opc_q      <= opc_d;
            inst_q     <= inst_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        opc_d      = opc_q;
        inst_d     = inst_q;
        misalign_d = misalign_q;

        if (redirect_valid_i) begin
            // A same-cycle handshake is treated as consumed, so flushing is safe.
            valid_d = 1'b0;
            pc_d    = redirect_pc_i;
            state_d = RUN;
        end else if (state_q == BOOT) begin
            state_d = RUN;
        end else if (state_q == RUN && space && pc_aligned) begin
            valid_d    = 1'b1;
            opc_d      = pc_q;
            inst_d     = rom_inst_i;
            misalign_d = 1'b0;
            pc_d       = pc_q + 64'd4;
        end else if (state_q == RUN && space) begin
            valid_d    = 1'b1;
            opc_d      = pc_q;
            inst_d     = 32'd0;
            misalign_d = 1'b1;
            state_d    = HALT;
        end else if (space && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign rom_ce_o       = (state_q == RUN) && pc_aligned;
    assign rom_addr_o     = pc_q;
    assign out_valid_o    = valid_q;
    assign out_pc_o       = opc_q;
    assign out_inst_o     = inst_q;
    assign out_misalign_o = misalign_q;

endmodule
`default_nettype wire
